// File: rtl/demux2_stream16_pkg.sv
// demux2_pkg: shared types and default sizes for the 1-to-2 stream demux.
//   chan_e       : destination channel encoding carried by in_sel
//   slot_state_e : EMPTY/FULL state of one output holding slot
//   DMX_WIDTH    : default data width
//   DMX_CNT_W    : default delivered-word counter width
package demux2_pkg;

  typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} chan_e;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

  localparam int DMX_WIDTH = 16;
  localparam int DMX_CNT_W = 8;

endpackage

// File: rtl/demux2_stream16_slot.sv
// demux_slot: one output channel of the demux. Holds a single word, tracks
// EMPTY/FULL, reports whether it can take a word this cycle, and counts the
// words handed to the consumer.
//
// Handshake: a word moves on an edge exactly when valid && ready. valid and q
// are stable while valid && !ready. load may only be raised while free is high.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : write d into the holding register this cycle
//   d        : incoming word
//   ready    : consumer ready
//   valid    : slot is FULL (also the visible FSM state)
//   q        : holding register
//   free     : slot can take a word this cycle (empty or draining)
//   cnt      : delivered-word counter, wraps silently
module demux_slot
  import demux2_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int CNT_W = DMX_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  slot_state_e state, state_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a load always leaves the slot FULL, even when the old word
  // drains on the same edge, which is what gives one word per cycle.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = SLOT_FULL;
    end else if (state == SLOT_FULL && ready) begin
      state_next = SLOT_EMPTY;
    end
  end

  // Outputs
  always_comb begin
    valid = (state == SLOT_FULL);
    free  = (state == SLOT_EMPTY) || ready;
  end

  // Holding register: only written on load, so it stays put while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  // Delivered-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (valid && ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux2_stream16.sv
// demux2_stream16: registered 1-to-2 stream demultiplexer. Each accepted
// input word is steered by in_sel into one of two independently
// back-pressured output slots.
//
// Handshake: every stream transfers a word on a rising edge where
// valid && ready. in_ready depends only on in_sel and the addressed slot
// (never on in_valid); outN_valid/outN_data hold while stalled.
//
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   in_valid, in_ready, in_sel, in_data : input stream, in_sel picks channel
//   out0_valid, out0_ready, out0_data   : channel 0 stream
//   out1_valid, out1_ready, out1_data   : channel 1 stream
//   cnt0, cnt1                          : delivered words per channel
module demux2_stream16
  import demux2_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int CNT_W = DMX_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  chan_e dest;
  logic  free0, free1;
  logic  load0, load1;

  // Only the addressed slot gates the input, so a stalled channel never
  // blocks words headed for the other one.
  always_comb begin
    dest     = chan_e'(in_sel);
    in_ready = (dest == CH1) ? free1 : free0;
    load0    = in_valid && in_ready && (dest == CH0);
    load1    = in_valid && in_ready && (dest == CH1);
  end

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk   (clk),
    .rst   (rst),
    .load  (load0),
    .d     (in_data),
    .ready (out0_ready),
    .valid (out0_valid),
    .q     (out0_data),
    .free  (free0),
    .cnt   (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk   (clk),
    .rst   (rst),
    .load  (load1),
    .d     (in_data),
    .ready (out1_ready),
    .valid (out1_valid),
    .q     (out1_data),
    .free  (free1),
    .cnt   (cnt1)
  );

endmodule

// File: tb/tb_demux2_stream16.sv
// tb_demux2_stream16: directed scenarios for demux2_stream16. Inputs change
// 1 ns after a rising edge; outputs are sampled there too (registered
// results) or just before the next edge (combinational in_ready).
module tb_demux2_stream16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b0;
  logic [15:0] in_data = '0;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
  logic [15:0] out1_data;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  demux2_stream16 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [15:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    tick();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %b exp 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b exp 0", out1_valid); end
    checks++; if (out0_data !== 16'h0000) begin errors++; $display("FAIL reset_out0_data got %h exp 0000", out0_data); end
    checks++; if (out1_data !== 16'h0000) begin errors++; $display("FAIL reset_out1_data got %h exp 0000", out1_data); end
    checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", cnt0, cnt1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h1234);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h1234) begin errors++; $display("FAIL single_out0 got v=%b d=%h exp v=1 d=1234", out0_valid, out0_data); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL single_cnt0_early got %0d exp 0", cnt0); end
    tick();
    checks++; if (cnt0 !== 8'd1 || out0_valid !== 1'b0) begin errors++; $display("FAIL single_cnt0 got cnt=%0d v=%b exp cnt=1 v=0", cnt0, out0_valid); end
    checks++; if (out1_valid !== 1'b0 || cnt1 !== 8'd0 || out1_data !== 16'h0000) begin errors++; $display("FAIL single_ch1_untouched got v=%b d=%h cnt=%0d exp 0/0000/0", out1_valid, out1_data, cnt1); end
  endtask

  task automatic test_alternate();
    logic [15:0] d;
    logic        s;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = (i % 2) == 1;
      d = 16'(i + 1);
      drive(1'b1, s, d);
      #3;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alt_in_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      if (s) begin
        checks++; if (out1_valid !== 1'b1 || out1_data !== d || out0_valid !== 1'b0) begin errors++; $display("FAIL alt_word[%0d] got v1=%b d1=%h v0=%b exp v1=1 d1=%h v0=0", i, out1_valid, out1_data, out0_valid, d); end
      end else begin
        checks++; if (out0_valid !== 1'b1 || out0_data !== d || out1_valid !== 1'b0) begin errors++; $display("FAIL alt_word[%0d] got v0=%b d0=%h v1=%b exp v0=1 d0=%h v1=0", i, out0_valid, out0_data, out1_valid, d); end
      end
    end
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (cnt0 !== 8'd3 || cnt1 !== 8'd2) begin errors++; $display("FAIL alt_counts got %0d/%0d exp 3/2", cnt0, cnt1); end
  endtask

  task automatic test_stall();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 16'hAAAA);
    tick();
    drive(1'b1, 1'b0, 16'hBBBB);
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    tick();
    checks++; if (out0_valid !== 1'b1 || out0_data !== 16'hAAAA) begin errors++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=aaaa", out0_valid, out0_data); end
    drive(1'b1, 1'b1, 16'hCCCC);
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_other_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (out1_valid !== 1'b1 || out1_data !== 16'hCCCC || out0_data !== 16'hAAAA) begin errors++; $display("FAIL stall_other_word got v1=%b d1=%h d0=%h exp 1/cccc/aaaa", out1_valid, out1_data, out0_data); end
    // Release: AAAA handshakes on this edge while BBBB loads behind it.
    out0_ready = 1'b1;
    drive(1'b1, 1'b0, 16'hBBBB);
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    checks++; if (out0_valid !== 1'b1 || out0_data !== 16'hBBBB || cnt0 !== 8'd4) begin errors++; $display("FAIL stall_b2b got v=%b d=%h cnt=%0d exp 1/bbbb/4", out0_valid, out0_data, cnt0); end
    checks++; if (out1_valid !== 1'b0 || cnt1 !== 8'd3) begin errors++; $display("FAIL stall_ch1_drain got v=%b cnt=%0d exp 0/3", out1_valid, cnt1); end
    tick();
    checks++; if (out0_valid !== 1'b0 || cnt0 !== 8'd5) begin errors++; $display("FAIL stall_final got v=%b cnt=%0d exp 0/5", out0_valid, cnt0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, words[i]);
      tick();
      checks++; if (out1_valid !== 1'b1 || out1_data !== words[i]) begin errors++; $display("FAIL b2b_word[%0d] got v=%b d=%h exp v=1 d=%h", i, out1_valid, out1_data, words[i]); end
    end
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (out1_valid !== 1'b0 || cnt1 !== 8'd6 || cnt0 !== 8'd5) begin errors++; $display("FAIL b2b_counts got v1=%b cnt1=%0d cnt0=%0d exp 0/6/5", out1_valid, cnt1, cnt0); end
  endtask

  task automatic test_wrap();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 16'(i));
      tick();
    end
    drive(1'b0, 1'b0, 16'h0000);
    checks++; if (cnt0 !== 8'd255 || out0_data !== 16'h00FF) begin errors++; $display("FAIL wrap_pre got cnt=%0d d=%h exp 255/00ff", cnt0, out0_data); end
    tick();
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL wrap_cnt0 got %0d exp 0", cnt0); end
    checks++; if (cnt1 !== 8'd0 || out1_valid !== 1'b0) begin errors++; $display("FAIL wrap_cnt1 got cnt=%0d v=%b exp 0/0", cnt1, out1_valid); end
  endtask

  task automatic test_async_reset();
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h7777);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h5555);
    tick();
    drive(1'b1, 1'b1, 16'h6666);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || cnt1 !== 8'd1) begin errors++; $display("FAIL areset_pre got v0=%b v1=%b cnt1=%0d exp 1/1/1", out0_valid, out1_valid, cnt1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL areset_valids got %b/%b exp 0/0", out0_valid, out1_valid); end
    checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || out0_data !== 16'h0000 || out1_data !== 16'h0000) begin errors++; $display("FAIL areset_state got cnt=%0d/%0d d=%h/%h exp zeros", cnt0, cnt1, out0_data, out1_data); end
    #1 rst = 1'b0;
    #1;
    in_sel = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready1 got %b exp 1", in_ready); end
    in_sel = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready0 got %b exp 1", in_ready); end
    tick();
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("FAIL areset_after got v=%b/%b cnt=%0d/%0d exp zeros", out0_valid, out1_valid, cnt0, cnt1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux2_stream16.md
# demux2_stream16

Registered 1-to-2 stream demultiplexer: the receive-side counterpart of the team's 16-bit 2:1 select path. It accepts one 16-bit word per valid/ready handshake and steers it, by a per-word destination bit, into one of two independently back-pressured output channels. Each output has a one-word holding register and a delivered-word counter. It sits between the time/adder datapath and two consumers, for example the display latch and the lap/split store.

## Interface
- `WIDTH`, 16: data width of input and both outputs.
- `CNT_W`, 8: width of each delivered-word counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: input handshake accepted this cycle when `in_valid && in_ready`.
- `in_sel` in 1: destination of the current word; 0 selects channel 0, 1 selects channel 1. Only meaningful while `in_valid` is high.
- `in_data` in WIDTH: input word.
- `out0_valid` out 1, `out0_ready` in 1, `out0_data` out WIDTH: channel 0 stream.
- `out1_valid` out 1, `out1_ready` in 1, `out1_data` out WIDTH: channel 1 stream.
- `cnt0` out CNT_W, `cnt1` out CNT_W: words delivered on each channel (output handshakes), modulo 2^CNT_W.

## Operation
- Per-channel state is EMPTY or FULL. `outN_valid` is 1 exactly when the channel is FULL. `outN_data` is the holding register.
- Channel N can take a word when `slot_freeN = !outN_valid || outN_ready`.
- `in_ready = in_sel ? slot_free1 : slot_free0`. This is combinational from `in_sel`, `outN_valid` and `outN_ready`; there is no path from `in_valid` to `in_ready`.
- Accept to channel N (`in_valid && in_ready && in_sel==N`): the holding register loads `in_data`, and the channel becomes or stays FULL.
- Channel N transitions:
  - FULL with `outN_ready` and no accept to N → EMPTY. Data is held, don't-care.
  - FULL with `outN_ready` and an accept to N in the same cycle → stays FULL with the new word. No bubble; one word per cycle sustained.
  - FULL with `!outN_ready` → stays FULL, data stable. `in_ready` is low for words targeting N.
- The channels are independent: channel 1 draining or stalling never blocks a word destined for channel 0, and the reverse.
- Counters: `cntN` increments on every `outN_valid && outN_ready`. It wraps from 2^CNT_W−1 to 0 with no flag.
- `outN_data` and `outN_valid` are stable while `outN_valid && !outN_ready`.

## Timing
- Reset values: `out0_valid=0`, `out1_valid=0`, `out0_data=0`, `out1_data=0`, `cnt0=0`, `cnt1=0`. `in_ready` follows from the reset state: 1.
- Assertion of `rst` mid-transfer drops both valids immediately (asynchronous). Held words are discarded and are not counted.
- Latency: a word accepted at edge k appears on `outN_valid`/`outN_data` after edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle when the consumer holds `outN_ready` high, regardless of alternation of `in_sel`.
- Counter update: `cntN` shows the new value in the cycle after the output handshake.

## Structure
- Shared package `demux2_pkg`:
  - `typedef enum logic {CH0=1'b0, CH1=1'b1} chan_e`
  - `typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e`
  - default width constants `DMX_WIDTH=16` and `DMX_CNT_W=8`.
- One sub-module `demux_slot`, instantiated twice. It contains the holding register, the EMPTY/FULL state, `slot_free`, and the delivered-word counter, with ports `clk`, `rst`, `load`, `d`, `ready`, `valid`, `q`, `free`, `cnt`.
- The top level contains only `in_ready` selection and per-slot `load` decode.

## Test plan
- Reset, then `in_valid=1`, `in_sel=0`, `in_data=16'h1234`, `out0_ready=1` → `out0_valid=1`, `out0_data=16'h1234` one cycle later; `cnt0=1` the cycle after; channel 1 untouched.
- Alternate `in_sel` 0,1,0,1 with data 16'h0001..16'h0004, both readies high → `out0` delivers 1,3 and `out1` delivers 2,4; one word/cycle, `in_ready` never low.
- Stall channel 0: load 16'hAAAA with `out0_ready=0`, then offer `in_sel=0`, 16'hBBBB → `in_ready=0` and `out0_data` held at 16'hAAAA. Then offer `in_sel=1`, 16'hCCCC → `in_ready=1` and `out1` receives 16'hCCCC. Release `out0_ready` → 16'hAAAA then 16'hBBBB delivered back-to-back.
- Channel 1 FULL with `out1_ready=1` and a new accept to 1 in the same cycle → `out1_valid` stays 1 and data advances with no bubble.
- 256 deliveries on channel 0 → `cnt0` reads 0 after the 256th handshake; `cnt1` unchanged.
- Assert `rst` for a partial cycle while both channels are FULL → both valids 0 and both counters 0 asynchronously; `in_ready=1` after release.
